keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
Parametrised matrix-keypad scanner, successor to the fixed 4x4 scanner. Drives active-low row strobes with a programmable dwell and samples active-low columns at the end of each dwell. Debounces every key over whole scan frames and reports press/release events through a valid/ready handshake. Also exposes a debounced key-state bitmap. Sits between the board keypad pins and game/control logic.

Parameters:
ROWS, 4, number of row strobes (>=2)
COLS, 4, number of column inputs (>=1)
SCAN_DIV, 1000, clk cycles each row is driven (>=2)
DEBOUNCE, 4, consecutive frames a changed raw level must persist before acceptance (>=1)
REPEAT_DELAY, 30, frames before first auto-repeat (KEYPAD_REPEAT_EN only)
REPEAT_RATE, 8, frames between later auto-repeats (KEYPAD_REPEAT_EN only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
col  in  COLS  column sense; 0 = key closed on the currently driven row
row  out  ROWS  row strobe, active-low one-cold; all ones when idle
keymap  out  ROWS*COLS  debounced state; bit r*COLS+c = 1 while pressed
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_code  out  KW=$clog2(ROWS*COLS)  key index r*COLS+c
evt_press  out  1  1 = press, 0 = release
evt_repeat  out  1  1 = auto-repeat press (present only with KEYPAD_REPEAT_EN)

Behaviour:
- Reset (async assert, sync release): row = all ones, keymap = 0, evt_valid = 0, evt_code = 0, evt_press = 0, evt_repeat = 0, all debounce counters = 0, FSM = SCAN at row 0 with dwell counter 0. Reset mid-operation aborts any scan or walk; no partial event survives.
- FSM SCAN: row r driven low (bit r = 0) for exactly SCAN_DIV cycles. col is sampled on the last dwell cycle into raw[r*COLS+c] = ~col[c]. After row ROWS-1, go to WALK.
- FSM WALK: key index k steps 0..ROWS*COLS-1, one key per cycle. For key k, if raw[k] != keymap[k], increment cnt[k]; else clear cnt[k]. When cnt[k] reaches DEBOUNCE, flip keymap[k], clear cnt[k], and emit an event with code k and press = new keymap[k].
- Handshake: an event loads the output register and sets evt_valid. The register is held stable until the cycle evt_valid && evt_ready. If key k needs to emit while evt_valid && !evt_ready, the walk stalls on k and commits no counter or keymap update until the slot frees. Events are never dropped and are emitted in ascending index order within a frame. Same-cycle accept and new load is allowed, giving one event per cycle at full throughput.
- row stays all ones during WALK. After k = ROWS*COLS-1 is processed, the FSM returns to SCAN at row 0. Minimum frame = ROWS*SCAN_DIV + ROWS*COLS cycles. Backpressure only lengthens frames.
- Latency: a level held stable from frame F onward flips keymap in the WALK of frame F+DEBOUNCE-1. A bounce that reverts within the window restarts the count.
- Counter widths: dwell $clog2(SCAN_DIV), cnt $clog2(DEBOUNCE+1). No wrap is possible; all counters clear on terminal count.
- Ghosting: no ghost rejection. Every reported closure is debounced independently.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: the most recently pressed key (a new press replaces the tracked key) becomes the repeat key. After REPEAT_DELAY full frames held, it emits press events with evt_repeat = 1, then one every REPEAT_RATE frames. Repeats are inserted in WALK at that key's index and follow the same stall rules. Release of the repeat key, or reset, stops repeating. Release of another key does not affect it.
- Undefined: no repeat logic, no evt_repeat port, no REPEAT_* counters. Each press yields exactly one event.

Test Plan:
All cases use ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3 unless noted.
1. Reset then release -> row = 1111 during reset. Then 1110 x4, 1101 x4, 1011 x4, 0111 x4, then 1111 for 16 WALK cycles, repeating. evt_valid = 0 throughout.
2. Hold key 6 (col[2]=0 while row[1] low) from frame 0 -> keymap[6] = 1 and evt_code = 6, press = 1 in the WALK of frame 2. Release -> press = 0 event 3 frames later.
3. Key 9 toggles pressed/released every frame for 6 frames -> no event, keymap = 0.
4. Keys 3 and 12 pressed in the same frame with evt_ready = 0 -> evt_valid = 1 with code 3 held 10 cycles, row = 1111 while stalled. After ready = 1, code 3 is accepted, then code 12 on the next cycle.
5. Assert reset mid-WALK with evt_valid = 1 -> all outputs return to reset values in the same cycle without waiting for a clock edge. keymap = 0 and no event after release until re-debounced.
6. KEYPAD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, hold key 0 -> press event with repeat = 0. Then repeat = 1 events 5 frames later and every 2 frames after that. Release -> one release event, repeats stop.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: active-low row strobes, frame-based debounce, valid/ready
// press/release events. Define KEYPAD_REPEAT_EN to add auto-repeat of the last pressed key.
module keypad_scan_ctrl #(
  parameter  int ROWS         = 4,
  parameter  int COLS         = 4,
  parameter  int SCAN_DIV     = 1000,
  parameter  int DEBOUNCE     = 4,
  parameter  int REPEAT_DELAY = 30,
  parameter  int REPEAT_RATE  = 8,
  localparam int NKEYS        = ROWS * COLS,
  localparam int KW           = $clog2(NKEYS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] col,
  output logic [ROWS-1:0] row,
  output logic [NKEYS-1:0] keymap,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [KW-1:0]   evt_code,
  output logic            evt_press
`ifdef KEYPAD_REPEAT_EN
  ,
  output logic            evt_repeat
`endif
);

  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [KW-1:0] KEY_LAST   = KW'(NKEYS - 1);
  localparam logic [CW-1:0] CNT_HIT    = CW'(DEBOUNCE);

  if (ROWS < 2 || COLS < 1 || SCAN_DIV < 2 || DEBOUNCE < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_scan_ctrl: parameter out of range");
  end

  typedef enum logic {SCAN, WALK} state_e;

  state_e           state_q, state_d;
  logic             run_q, run_d;
  logic [RW-1:0]    row_idx_q, row_idx_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [KW-1:0]    key_q, key_d;
  logic [ROWS-1:0]  row_q, row_d;
  logic [NKEYS-1:0] raw_q, raw_d;
  logic [NKEYS-1:0] keymap_q, keymap_d;
  logic [CW-1:0]    cnt_q [NKEYS];
  logic [CW-1:0]    cnt_d [NKEYS];
  logic             evt_valid_q, evt_valid_d;
  logic [KW-1:0]    evt_code_q, evt_code_d;
  logic             evt_press_q, evt_press_d;

  logic             slot_free, differ, deb_hit, rep_hit, emit;
  logic [CW-1:0]    cnt_inc;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int PW      = $clog2(REP_MAX + 1);

  logic [KW-1:0] rep_key_q, rep_key_d;
  logic          rep_act_q, rep_act_d;
  logic          rep_first_q, rep_first_d;
  logic [PW-1:0] rep_cnt_q, rep_cnt_d;
  logic          evt_repeat_q, evt_repeat_d;
  logic [PW-1:0] rep_inc, rep_target;
  logic          rep_here;
`endif

  // NOTE: every _d gets its hold value before any branch, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    run_d       = 1'b1;
    row_idx_d   = row_idx_q;
    dwell_d     = dwell_q;
    key_d       = key_q;
    raw_d       = raw_q;
    keymap_d    = keymap_q;
    cnt_d       = cnt_q;
    evt_valid_d = evt_valid_q && !evt_ready;
    evt_code_d  = evt_code_q;
    evt_press_d = evt_press_q;

    slot_free = !evt_valid_q || evt_ready;
    differ    = raw_q[key_q] ^ keymap_q[key_q];
    cnt_inc   = cnt_q[key_q] + 1'b1;
    deb_hit   = (state_q == WALK) && differ && (cnt_inc == CNT_HIT);
    rep_hit   = 1'b0;

`ifdef KEYPAD_REPEAT_EN
    rep_key_d    = rep_key_q;
    rep_act_d    = rep_act_q;
    rep_first_d  = rep_first_q;
    rep_cnt_d    = rep_cnt_q;
    evt_repeat_d = evt_repeat_q;
    rep_inc      = rep_cnt_q + 1'b1;
    rep_target   = rep_first_q ? PW'(REPEAT_DELAY) : PW'(REPEAT_RATE);
    rep_here     = (state_q == WALK) && rep_act_q && (rep_key_q == key_q) && !deb_hit;
    rep_hit      = rep_here && (rep_inc == rep_target);
`endif

    emit = deb_hit || rep_hit;

    // The first cycle after reset release only arms the row driver; scanning starts next.
    if (run_q) begin
      case (state_q)
        SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            for (int r = 0; r < ROWS; r++) begin
              if (RW'(r) == row_idx_q) begin
                for (int c = 0; c < COLS; c++) raw_d[r*COLS + c] = ~col[c];
              end
            end
            dwell_d = '0;
            if (row_idx_q == ROW_LAST) begin
              state_d   = WALK;
              row_idx_d = '0;
              key_d     = '0;
            end else begin
              row_idx_d = row_idx_q + 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        WALK: begin
          // A key that must emit while the slot is occupied holds the walk untouched.
          if (!emit || slot_free) begin
            cnt_d[key_q] = (differ && !deb_hit) ? cnt_inc : '0;
            if (deb_hit) begin
              keymap_d[key_q] = !keymap_q[key_q];
              evt_valid_d     = 1'b1;
              evt_code_d      = key_q;
              evt_press_d     = !keymap_q[key_q];
            end else if (rep_hit) begin
              evt_valid_d = 1'b1;
              evt_code_d  = key_q;
              evt_press_d = 1'b1;
            end
`ifdef KEYPAD_REPEAT_EN
            if (deb_hit) evt_repeat_d = 1'b0;
            else if (rep_hit) evt_repeat_d = 1'b1;
            if (deb_hit && !keymap_q[key_q]) begin
              rep_key_d   = key_q;
              rep_act_d   = 1'b1;
              rep_first_d = 1'b1;
              rep_cnt_d   = '0;
            end else if (deb_hit && rep_act_q && (rep_key_q == key_q)) begin
              rep_act_d = 1'b0;
            end else if (rep_here) begin
              rep_cnt_d = rep_hit ? '0 : rep_inc;
              if (rep_hit) rep_first_d = 1'b0;
            end
`endif
            if (key_q == KEY_LAST) state_d = SCAN;
            else key_d = key_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    row_d = '1;
    if (state_d == SCAN) row_d[row_idx_d] = 1'b0;
  end

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      run_q       <= 1'b0;
      row_idx_q   <= '0;
      dwell_q     <= '0;
      key_q       <= '0;
      row_q       <= '1;
      raw_q       <= '0;
      keymap_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_press_q <= 1'b0;
      // NOTE: the counter array is reset too; a stale count would fire a spurious event.
      for (int k = 0; k < NKEYS; k++) cnt_q[k] <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_key_q    <= '0;
      rep_act_q    <= 1'b0;
      rep_first_q  <= 1'b0;
      rep_cnt_q    <= '0;
      evt_repeat_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      row_idx_q   <= row_idx_d;
      dwell_q     <= dwell_d;
      key_q       <= key_d;
      row_q       <= row_d;
      raw_q       <= raw_d;
      keymap_q    <= keymap_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_press_q <= evt_press_d;
      cnt_q       <= cnt_d;
`ifdef KEYPAD_REPEAT_EN
      rep_key_q    <= rep_key_d;
      rep_act_q    <= rep_act_d;
      rep_first_q  <= rep_first_d;
      rep_cnt_q    <= rep_cnt_d;
      evt_repeat_q <= evt_repeat_d;
`endif
    end
  end

  assign row       = row_q;
  assign keymap    = keymap_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_press = evt_press_q;
`ifdef KEYPAD_REPEAT_EN
  assign evt_repeat = evt_repeat_q;
`endif

endmodule
